eth_manchester_tx: RTL and testbench



---
 rtl/eth_pkg.sv | 31 +++
 rtl/eth_nlp_timer.sv | 35 +++
 rtl/eth_manchester_tx.sv | 187 ++++++++++++++++++
 tb/tb_eth_manchester_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the 10BASE-T transmit line stage.
// Contents:
//   eth_tx_state_t : line FSM states (IDLE, NLP, DATA, TPIDL)
//   line_t         : differential driver pair {p, n}
//   LINE_POS       : td_p=1, td_n=0 (NLP and TP_IDL level)
//   LINE_OFF       : td_p=0, td_n=0 (line released)
//   DEF_*          : default timing at 20 MHz, also used by the receiver's
//                    link-pulse detector
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NLP   = 2'd1,
    DATA  = 2'd2,
    TPIDL = 2'd3
  } eth_tx_state_t;

  typedef struct packed {
    logic p;
    logic n;
  } line_t;

  localparam line_t LINE_POS = '{p: 1'b1, n: 1'b0};
  localparam line_t LINE_OFF = '{p: 1'b0, n: 1'b0};

  // 16 ms between link pulses, 100 ns pulse, 250 ns TP_IDL hold
  localparam int DEF_NLP_PERIOD   = 320000;
  localparam int DEF_NLP_WIDTH    = 2;
  localparam int DEF_TPIDL_CYCLES = 5;

endpackage

// File: rtl/eth_nlp_timer.sv
// Idle-time counter for normal link pulse scheduling.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : force count back to zero
//   en       : advance the count this cycle
//   fire     : one-cycle flag, high while en and count is NLP_PERIOD-1
// The pulse width itself belongs to the line FSM; this block only says when.
module eth_nlp_timer
  import eth_pkg::*;
#(
  parameter int NLP_PERIOD = DEF_NLP_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic fire
);

  localparam int CW = (NLP_PERIOD > 1) ? $clog2(NLP_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(NLP_PERIOD - 1);

  logic [CW-1:0] cnt;

  assign fire = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= fire ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/eth_manchester_tx.sv
// Manchester encoder and line sequencer for the 10BASE-T transmitter.
// Ports:
//   clk, rst       : 20 MHz transmit clock (one cycle = one half-bit),
//                    synchronous active-high reset
//   tx_sck,tx_mosi : serial bit stream from the serializer, MSB-first
//   td_p, td_n     : registered differential line drivers
//   busy           : high in DATA or TPIDL
//   sync_err       : sticky, a strobe landed in the first half of a bit
//   frame_cnt      : frames started, wraps at 16 bits
//   state_dbg      : current FSM state
//
// Stream handshake: tx_sck is a valid-only strobe with no backpressure.
// A bit is transferred on each 0->1 transition of the registered tx_sck;
// tx_mosi is sampled in the same cycle. There is no ready; a strobe that
// arrives while the current bit is still in its first half is dropped and
// flagged on sync_err.
module eth_manchester_tx
  import eth_pkg::*;
#(
  parameter int NLP_PERIOD   = DEF_NLP_PERIOD,
  parameter int NLP_WIDTH    = DEF_NLP_WIDTH,
  parameter int TPIDL_CYCLES = DEF_TPIDL_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_sck,
  input  logic          tx_mosi,
  output logic          td_p,
  output logic          td_n,
  output logic          busy,
  output logic          sync_err,
  output logic [15:0]   frame_cnt,
  output eth_tx_state_t state_dbg
);

  localparam int HOLD_MAX = (NLP_WIDTH > TPIDL_CYCLES) ? NLP_WIDTH : TPIDL_CYCLES;
  localparam int HW       = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] NLP_LAST   = HW'(NLP_WIDTH - 1);
  localparam logic [HW-1:0] TPIDL_LAST = HW'(TPIDL_CYCLES - 1);

  // input sampling and rising-edge detect
  logic s_sck, s_sck_d, s_mosi, strobe;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_sck   <= 1'b0;
      s_sck_d <= 1'b0;
      s_mosi  <= 1'b0;
    end else begin
      s_sck   <= tx_sck;
      s_sck_d <= s_sck;
      s_mosi  <= tx_mosi;
    end
  end

  assign strobe = s_sck & ~s_sck_d;

  // FSM state
  eth_tx_state_t state, state_nx;
  logic          cur_bit, cur_bit_nx;
  logic          phase, phase_nx;      // 0: first half (~bit), 1: second half (bit)
  logic [HW-1:0] hold_cnt, hold_nx;    // cycles spent in NLP / TPIDL
  logic          sync_err_nx;
  logic [15:0]   frame_cnt_nx;
  line_t         line_nx;
  logic          busy_nx;
  logic          nlp_fire;

  // Counts idle time only; leaving IDLE parks it at zero so every return to
  // IDLE restarts the full NLP period.
  eth_nlp_timer #(
    .NLP_PERIOD(NLP_PERIOD)
  ) u_nlp_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(state != IDLE),
    .en   (state == IDLE),
    .fire (nlp_fire)
  );

  // state register (outputs registered alongside)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_bit   <= 1'b0;
      phase     <= 1'b0;
      hold_cnt  <= '0;
      sync_err  <= 1'b0;
      frame_cnt <= '0;
      td_p      <= 1'b0;
      td_n      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_bit   <= cur_bit_nx;
      phase     <= phase_nx;
      hold_cnt  <= hold_nx;
      sync_err  <= sync_err_nx;
      frame_cnt <= frame_cnt_nx;
      td_p      <= line_nx.p;
      td_n      <= line_nx.n;
      busy      <= busy_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx     = state;
    cur_bit_nx   = cur_bit;
    phase_nx     = phase;
    hold_nx      = hold_cnt;
    sync_err_nx  = sync_err;
    frame_cnt_nx = frame_cnt;
    if (state != DATA && strobe) begin
      // frame start; any NLP or TP_IDL in progress is cut short
      state_nx     = DATA;
      cur_bit_nx   = s_mosi;
      phase_nx     = 1'b0;
      hold_nx      = '0;
      sync_err_nx  = 1'b0;
      frame_cnt_nx = frame_cnt + 16'd1;
    end else begin
      unique case (state)
        IDLE: begin
          if (nlp_fire) begin
            state_nx = NLP;
            hold_nx  = '0;
          end
        end
        NLP: begin
          if (hold_cnt == NLP_LAST) begin
            state_nx = IDLE;
            hold_nx  = '0;
          end else begin
            hold_nx = hold_cnt + HW'(1);
          end
        end
        DATA: begin
          if (!phase) begin
            phase_nx = 1'b1;
            if (strobe) sync_err_nx = 1'b1;
          end else if (strobe) begin
            cur_bit_nx = s_mosi;
            phase_nx   = 1'b0;
          end else begin
            state_nx = TPIDL;
            hold_nx  = '0;
          end
        end
        TPIDL: begin
          if (hold_cnt == TPIDL_LAST) begin
            state_nx = IDLE;
            hold_nx  = '0;
          end else begin
            hold_nx = hold_cnt + HW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // output logic, evaluated on the next state so the registers line up
  // with the state they describe
  always_comb begin
    line_nx = LINE_OFF;
    busy_nx = 1'b0;
    unique case (state_nx)
      IDLE: line_nx = LINE_OFF;
      NLP:  line_nx = LINE_POS;
      DATA: begin
        // a 1 goes low->high at mid-bit, a 0 goes high->low
        line_nx.p = phase_nx ? cur_bit_nx : ~cur_bit_nx;
        line_nx.n = phase_nx ? ~cur_bit_nx : cur_bit_nx;
        busy_nx   = 1'b1;
      end
      TPIDL: begin
        line_nx = LINE_POS;
        busy_nx = 1'b1;
      end
      default: line_nx = LINE_OFF;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_eth_manchester_tx.sv
// Bench for eth_manchester_tx with a short NLP period. A directed table
// covers reset and one 0xA5 byte; hand sequences cover NLP timing, NLP
// abort, a late strobe, mid-frame reset and frame counter wrap; a random
// phase runs against a queue-based line model.
module tb_eth_manchester_tx;
  import eth_pkg::*;

  localparam int P = 16;
  localparam int W = 2;
  localparam int T = 5;

  logic          clk;
  logic          rst;
  logic          tx_sck;
  logic          tx_mosi;
  logic          td_p;
  logic          td_n;
  logic          busy;
  logic          sync_err;
  logic [15:0]   frame_cnt;
  eth_tx_state_t state_dbg;

  int total = 0;
  int bad   = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  eth_manchester_tx #(
    .NLP_PERIOD  (P),
    .NLP_WIDTH   (W),
    .TPIDL_CYCLES(T)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_sck   (tx_sck),
    .tx_mosi  (tx_mosi),
    .td_p     (td_p),
    .td_n     (td_n),
    .busy     (busy),
    .sync_err (sync_err),
    .frame_cnt(frame_cnt),
    .state_dbg(state_dbg)
  );

  // reference model: a frame is a queue of pending half-bit line levels;
  // pulses are a countdown of remaining positive cycles; idle is an age
  typedef enum int {M_IDLE, M_NLP, M_FRAME, M_TPIDL} mode_t;
  mode_t       m_mode;
  int          m_age;
  int          m_left;
  logic        m_out;
  logic        m_sync;
  logic [15:0] m_fc;
  logic        h1, h2, hm;        // input samples as the DUT last saw them
  logic [0:0]  exp_q[$];

  task automatic model_reset();
    m_mode = M_IDLE;
    m_age  = 0;
    m_left = 0;
    m_out  = 1'b0;
    m_sync = 1'b0;
    m_fc   = 16'd0;
    h1     = 1'b0;
    h2     = 1'b0;
    hm     = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic r, input logic sck, input logic mosi);
    logic stb;
    logic b;
    if (r) begin
      model_reset();
      return;
    end
    stb = h1 & ~h2;
    b   = hm;
    if (stb && m_mode != M_FRAME) begin
      m_mode = M_FRAME;
      m_fc   = m_fc + 16'd1;
      m_sync = 1'b0;
      exp_q.delete();
      exp_q.push_back(~b);
      exp_q.push_back(b);
    end else if (m_mode == M_FRAME) begin
      if (exp_q.size() != 0) begin
        if (stb) m_sync = 1'b1;
      end else if (stb) begin
        exp_q.push_back(~b);
        exp_q.push_back(b);
      end else begin
        m_mode = M_TPIDL;
        m_left = T;
      end
    end else if (m_mode == M_IDLE) begin
      m_age++;
      if (m_age == P) begin
        m_mode = M_NLP;
        m_left = W;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_mode = M_IDLE;
        m_age  = 0;
      end
    end
    if (m_mode == M_FRAME) m_out = exp_q.pop_front();
    else                   m_out = (m_mode == M_NLP || m_mode == M_TPIDL);
    h2 = h1;
    h1 = sck;
    hm = mosi;
  endtask

  function automatic logic [21:0] model_vec();
    eth_tx_state_t s;
    case (m_mode)
      M_NLP:   s = NLP;
      M_FRAME: s = DATA;
      M_TPIDL: s = TPIDL;
      default: s = IDLE;
    endcase
    return {s, m_out, (m_mode == M_FRAME) ? ~m_out : 1'b0,
            (m_mode == M_FRAME || m_mode == M_TPIDL), m_sync, m_fc};
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one clock cycle, model step, full-state compare
  task automatic cycle(input logic r, input logic s, input logic m, input string tag);
    @(negedge clk);
    rst     = r;
    tx_sck  = s;
    tx_mosi = m;
    @(posedge clk);
    model_step(r, s, m);
    #1;
    check(tag, {state_dbg, td_p, td_n, busy, sync_err, frame_cnt}, model_vec());
  endtask

  typedef struct {
    logic        r;
    logic        s;
    logic        m;
    logic        p;
    logic        n;
    logic        bz;
    logic [15:0] fc;
  } vec_t;

  vec_t tv[25];

  initial begin
    logic exp_hi;
    int   nbits;
    int   gap;
    int   idle;

    rst     = 1'b1;
    tx_sck  = 1'b0;
    tx_mosi = 1'b0;
    model_reset();

    // reset, then 0xA5 MSB-first; expected values after each edge
    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
    tv[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    tv[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
    tv[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1};
    tv[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1};
    tv[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      rst     = tv[i].r;
      tx_sck  = tv[i].s;
      tx_mosi = tv[i].m;
      @(posedge clk);
      model_step(tv[i].r, tv[i].s, tv[i].m);
      #1;
      check($sformatf("vec%0d", i), {td_p, td_n, busy, sync_err, frame_cnt},
            {tv[i].p, tv[i].n, tv[i].bz, 1'b0, tv[i].fc});
    end

    // idle link pulses: high for W cycles every P+W cycles
    cycle(1'b1, 1'b0, 1'b0, "idle_rst");
    for (int c = 1; c <= 40; c++) begin
      cycle(1'b0, 1'b0, 1'b0, "idle");
      exp_hi = (c >= P) && (((c - P) % (P + W)) < W);
      check("nlp_idle", {td_p, td_n, busy}, {exp_hi, 2'b00});
    end

    // strobe sampled on the edge the NLP starts: pulse cut after one cycle
    cycle(1'b1, 1'b0, 1'b0, "abort_rst");
    for (int c = 1; c <= 42; c++) begin
      cycle(1'b0, c == P, c == P, "nlp_abort");
      if (c == P)      check("abort_pulse_on", {state_dbg, td_p}, {NLP, 1'b1});
      if (c == P + 1)  check("abort_data_start", {busy, td_p, td_n, frame_cnt},
                             {1'b1, 1'b0, 1'b1, 16'd1});
      if (c == 39)     check("abort_next_nlp_pre", td_p, 1'b0);
      if (c == 40)     check("abort_next_nlp", td_p, 1'b1);
    end

    // late strobe: 3-cycle gap between bits 2 and 3
    cycle(1'b1, 1'b0, 1'b0, "gap_rst");
    for (int c = 1; c <= 34; c++) begin
      cycle(1'b0, (c == 2 || c == 4 || c == 7 || c == 9 || c == 11),
            1'($urandom_range(0, 1)), "late_strobe");
    end

    // reset while bit 4 is on the line: no TP_IDL afterwards
    cycle(1'b1, 1'b0, 1'b0, "mid_rst_pre");
    for (int c = 1; c <= 20; c++) begin
      cycle(c == 10, (c == 2 || c == 4 || c == 6 || c == 8), 1'b1, "mid_rst");
      if (c == 9)  check("mid_rst_in_frame", {busy, frame_cnt}, {1'b1, 16'd1});
      if (c == 10) check("mid_rst_edge", {state_dbg, td_p, td_n, busy, frame_cnt},
                         {IDLE, 3'b000, 16'd0});
      if (c > 10)  check("mid_rst_no_tpidl", {td_p, td_n, busy}, 3'b000);
    end

    // frame counter wrap: preload 0xFFFF over one quiet idle edge
    cycle(1'b1, 1'b0, 1'b0, "wrap_rst");
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 1'b0, "wrap_idle");
    @(negedge clk);
    rst     = 1'b0;
    tx_sck  = 1'b0;
    tx_mosi = 1'b0;
    force dut.frame_cnt = 16'hFFFF;
    @(posedge clk);
    model_step(1'b0, 1'b0, 1'b0);
    m_fc = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    check("wrap_preload", frame_cnt, 16'hFFFF);
    cycle(1'b0, 1'b1, 1'b0, "wrap_bit");
    cycle(1'b0, 1'b0, 1'b0, "wrap_start");
    check("wrap_to_zero", {busy, frame_cnt}, {1'b1, 16'd0});
    for (int c = 0; c < 10; c++) cycle(1'b0, 1'b0, 1'b0, "wrap_tail");

    // random bursts against the model
    for (int burst = 0; burst < 80; burst++) begin
      if ($urandom_range(0, 15) == 0) cycle(1'b1, 1'b0, 1'b0, "rand_rst");
      nbits = $urandom_range(1, 10);
      for (int i = 0; i < nbits; i++) begin
        cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), "rand");
        gap = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 4) : 1;
        for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), "rand");
      end
      idle = $urandom_range(0, 40);
      for (int g = 0; g < idle; g++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
